// File: rtl/gate_tt_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module : gate_chk_pkg
// Purpose: Shared definitions for the gate truth-table checker: FSM state
//          encoding and reference truth tables for common gates.
//          Truth-table bit v is the expected gate output for input vector v
//          (vector bit 0 drives gate input A, bit 1 drives B, ...).
// Rev    : 1.0 - initial release
// ============================================================================
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [7:0] TT_AND3  = 8'h80;

endpackage
`default_nettype wire

// File: rtl/gate_tt_checker_if.sv
`default_nettype none
// ============================================================================
// Module : gate_tt_checker_if
// Purpose: Bundle of run-control, gate-pin and result signals between the
//          truth-table checker and whatever hosts it.
//          master : host side  (drives START, returns gate output Y_IN)
//          slave  : checker    (drives gate inputs A_OUT and all results)
// Signals: START, A_OUT[N_IN], Y_IN, BUSY, DONE, PASS, ERR_CNT[N_IN+1],
//          FAIL_VEC[N_IN], FAIL_VALID
// Rev    : 1.0 - initial release
// ============================================================================
interface gate_tt_checker_if #(
  parameter int N_IN = 2
);
  logic            START;
  logic [N_IN-1:0] A_OUT;
  logic            Y_IN;
  logic            BUSY;
  logic            DONE;
  logic            PASS;
  logic [N_IN:0]   ERR_CNT;
  logic [N_IN-1:0] FAIL_VEC;
  logic            FAIL_VALID;

  modport master (
    output START, Y_IN,
    input  A_OUT, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC, FAIL_VALID
  );

  modport slave (
    input  START, Y_IN,
    output A_OUT, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC, FAIL_VALID
  );
endinterface
`default_nettype wire

// File: rtl/gate_tt_checker_settle_timer.sv
`default_nettype none
// ============================================================================
// Module : settle_timer
// Purpose: Loadable down-counter used to hold each test vector for SETTLE
//          cycles before the sample cycle. Loading writes SETTLE-1; the
//          counter then counts down to zero and stops there.
// Ports  : clk      in  clock
//          rst_n    in  asynchronous active-low reset
//          i_load   in  load SETTLE-1 (has priority over i_dec)
//          i_dec    in  decrement by one
//          o_zero   out counter equals zero
// Rev    : 1.0 - initial release
// ============================================================================
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_load,
  input  wire logic i_dec,
  output logic      o_zero
);
  import gate_chk_pkg::*;

  localparam int            W      = $clog2(SETTLE) + 1;
  localparam logic [W-1:0]  c_LOAD = W'(SETTLE - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_LOAD;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/gate_tt_checker.sv
`default_nettype none
// ============================================================================
// Module : gate_tt_checker
// Purpose: Sequential truth-table sweep engine. On START it drives every
//          input vector 0..2^N_IN-1 onto a combinational gate under test,
//          holds each for SETTLE cycles plus one sample cycle, compares the
//          gate output against EXPECT and reports pass/fail, the mismatch
//          count and the first failing vector.
// Ports  : CLK          in   rising-edge clock
//          RST_N        in   asynchronous active-low reset
//          bus (slave)  START in, Y_IN in, A_OUT out, BUSY out, DONE out,
//                       PASS out, ERR_CNT out, FAIL_VEC out, FAIL_VALID out
// Rev    : 1.0 - initial release
// ============================================================================
module gate_tt_checker
  import gate_chk_pkg::*;
#(
  parameter int                   N_IN   = 2,
  parameter int                   SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECT = TT_AND2
) (
  input  wire logic         CLK,
  input  wire logic         RST_N,
  gate_tt_checker_if.slave  bus
);

  state_t          r_state;
  state_t          w_state_nxt;

  logic [N_IN-1:0] r_a_out;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [N_IN:0]   r_err_cnt;
  logic [N_IN-1:0] r_fail_vec;
  logic            r_fail_valid;

  logic            w_accept;
  logic            w_load;
  logic            w_dec;
  logic            w_sample;
  logic            w_zero;
  logic            w_last;
  logic            w_mismatch;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk    (CLK),
    .rst_n  (RST_N),
    .i_load (w_load),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  assign w_last     = &r_a_out;
  // Only meaningful in SAMPLE; Y_IN has had SETTLE cycles to settle by then.
  assign w_mismatch = w_sample && (bus.Y_IN != EXPECT[r_a_out]);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.START) begin
          w_accept    = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (w_zero) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        w_sample = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_FINISH;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Vector counter and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a_out      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
      r_fail_vec   <= '0;
      r_fail_valid <= 1'b0;
    end else begin
      // DONE is high exactly for the FINISH cycle.
      r_done <= w_sample && w_last;

      if (w_accept) begin
        r_a_out      <= '0;
        r_busy       <= 1'b1;
        r_pass       <= 1'b0;
        r_err_cnt    <= '0;
        r_fail_vec   <= '0;
        r_fail_valid <= 1'b0;
      end

      if (w_sample) begin
        if (w_mismatch) begin
          r_err_cnt <= r_err_cnt + 1'b1;
          if (!r_fail_valid) begin
            r_fail_vec   <= r_a_out;
            r_fail_valid <= 1'b1;
          end
        end
        if (w_last) begin
          // Fold in the final sample so PASS is correct in the DONE cycle.
          r_pass <= (r_err_cnt == '0) && !w_mismatch;
        end else begin
          r_a_out <= r_a_out + 1'b1;
        end
      end

      if (r_state == ST_FINISH) begin
        r_a_out <= '0;
        r_busy  <= 1'b0;
      end
    end
  end

  assign bus.A_OUT      = r_a_out;
  assign bus.BUSY       = r_busy;
  assign bus.DONE       = r_done;
  assign bus.PASS       = r_pass;
  assign bus.ERR_CNT    = r_err_cnt;
  assign bus.FAIL_VEC   = r_fail_vec;
  assign bus.FAIL_VALID = r_fail_valid;

endmodule
`default_nettype wire

// File: tb/tb_gate_tt_checker.sv
`default_nettype none
// ============================================================================
// Module : tb_gate_tt_checker
// Purpose: Self-checking bench for gate_tt_checker. Two instances: a default
//          2-input/SETTLE=2/AND2 checker and a 3-input/SETTLE=1/AND3 checker.
//          Gate models feeding Y_IN are selectable per run.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_gate_tt_checker;
  import gate_chk_pkg::*;

  localparam int M_AND  = 0;
  localparam int M_OR   = 1;
  localparam int M_ONE  = 2;
  localparam int M_ZERO = 3;
  localparam int M_XOR  = 4;
  localparam int M_NAND = 5;

  typedef struct {
    bit pass;
    int err;
    int fvec;
    bit fvalid;
  } res_t;

  typedef struct {
    int   dut;
    int   mode;
    res_t exp;
  } vec_t;

  typedef struct {
    int a, busy, done, pass, err, fvec, fvalid;
  } snap_t;

  logic clk;
  logic rst_n;
  int   mode0;
  int   mode1;
  int   total;
  int   bad;
  res_t q0[$];
  res_t q1[$];

  gate_tt_checker_if #(.N_IN(2)) bus0 ();
  gate_tt_checker_if #(.N_IN(3)) bus1 ();

  gate_tt_checker #(
    .N_IN   (2),
    .SETTLE (2),
    .EXPECT (TT_AND2)
  ) dut0 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus0)
  );

  gate_tt_checker #(
    .N_IN   (3),
    .SETTLE (1),
    .EXPECT (TT_AND3)
  ) dut1 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate under test models over the low n bits of a.
  function automatic logic model(input int mode, input int a, input int n);
    logic all1, any1, par;
    all1 = 1'b1;
    any1 = 1'b0;
    par  = 1'b0;
    for (int i = 0; i < n; i++) begin
      all1 = all1 & a[i];
      any1 = any1 | a[i];
      par  = par ^ a[i];
    end
    case (mode)
      M_AND:   return all1;
      M_OR:    return any1;
      M_ONE:   return 1'b1;
      M_ZERO:  return 1'b0;
      M_XOR:   return par;
      M_NAND:  return ~all1;
      default: return 1'b0;
    endcase
  endfunction

  assign bus0.Y_IN = model(mode0, int'(bus0.A_OUT), 2);
  assign bus1.Y_IN = model(mode1, int'(bus1.A_OUT), 3);

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic snap_t snap(input int d);
    snap_t s;
    if (d == 0) begin
      s.a = int'(bus0.A_OUT);   s.busy = int'(bus0.BUSY);  s.done = int'(bus0.DONE);
      s.pass = int'(bus0.PASS); s.err = int'(bus0.ERR_CNT);
      s.fvec = int'(bus0.FAIL_VEC); s.fvalid = int'(bus0.FAIL_VALID);
    end else begin
      s.a = int'(bus1.A_OUT);   s.busy = int'(bus1.BUSY);  s.done = int'(bus1.DONE);
      s.pass = int'(bus1.PASS); s.err = int'(bus1.ERR_CNT);
      s.fvec = int'(bus1.FAIL_VEC); s.fvalid = int'(bus1.FAIL_VALID);
    end
    return s;
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 0) bus0.START = v;
    else        bus1.START = v;
  endtask

  task automatic cmp_result(input string tag, input snap_t s, input res_t e);
    check({tag, " PASS"},       s.pass,   int'(e.pass));
    check({tag, " ERR_CNT"},    s.err,    e.err);
    check({tag, " FAIL_VALID"}, s.fvalid, int'(e.fvalid));
    if (e.fvalid) check({tag, " FAIL_VEC"}, s.fvec, e.fvec);
  endtask

  // Scoreboard: every DONE pulse consumes one expected result.
  always @(negedge clk) begin
    snap_t s;
    res_t  e;
    s = snap(0);
    if (s.done != 0) begin
      if (q0.size() == 0) begin
        check("dut0 unexpected DONE", 1, 0);
      end else begin
        e = q0.pop_front();
        cmp_result("dut0", s, e);
      end
    end
    s = snap(1);
    if (s.done != 0) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected DONE", 1, 0);
      end else begin
        e = q1.pop_front();
        cmp_result("dut1", s, e);
      end
    end
  end

  // One full run: pulse START, follow the vector sequence, check DONE latency.
  task automatic run(input int d, input int mode, input res_t e);
    int    cyc;
    int    hold;
    int    lat;
    snap_t s;
    hold = (d == 0) ? 3 : 2;
    lat  = ((d == 0) ? 4 : 8) * hold;
    if (d == 0) begin mode0 = mode; q0.push_back(e); end
    else        begin mode1 = mode; q1.push_back(e); end
    @(negedge clk);
    set_start(d, 1'b1);
    @(negedge clk);
    set_start(d, 1'b0);
    cyc = 0;
    s   = snap(d);
    check("cleared ERR_CNT on accept", s.err, 0);
    check("cleared FAIL_VALID on accept", s.fvalid, 0);
    check("cleared PASS on accept", s.pass, 0);
    while (s.done == 0 && cyc < 100) begin
      if (cyc < lat) begin
        check("A_OUT step", s.a, cyc / hold);
        check("BUSY in run", s.busy, 1);
      end
      @(negedge clk);
      cyc++;
      s = snap(d);
    end
    check("DONE latency edges", cyc, lat);
    check("BUSY in FINISH", s.busy, 1);
    @(negedge clk);
    s = snap(d);
    check("DONE one cycle", s.done, 0);
    check("BUSY after FINISH", s.busy, 0);
    check("A_OUT back to 0", s.a, 0);
    check("PASS held", s.pass, int'(e.pass));
    check("ERR_CNT held", s.err, e.err);
  endtask

  vec_t tbl[11];

  initial begin
    snap_t s;
    int    ndone, first, second, k;
    res_t  r_and;
    total = 0;
    bad   = 0;
    mode0 = M_AND;
    mode1 = M_AND;
    bus0.START = 1'b0;
    bus1.START = 1'b0;
    rst_n = 1'b0;

    tbl[0]  = '{0, M_AND,  '{1'b1, 0, 0, 1'b0}};
    tbl[1]  = '{0, M_OR,   '{1'b0, 2, 1, 1'b1}};
    tbl[2]  = '{0, M_ONE,  '{1'b0, 3, 0, 1'b1}};
    tbl[3]  = '{0, M_AND,  '{1'b1, 0, 0, 1'b0}};
    tbl[4]  = '{0, M_ZERO, '{1'b0, 1, 3, 1'b1}};
    tbl[5]  = '{0, M_XOR,  '{1'b0, 3, 1, 1'b1}};
    tbl[6]  = '{0, M_NAND, '{1'b0, 4, 0, 1'b1}};
    tbl[7]  = '{1, M_AND,  '{1'b1, 0, 0, 1'b0}};
    tbl[8]  = '{1, M_OR,   '{1'b0, 6, 1, 1'b1}};
    tbl[9]  = '{1, M_NAND, '{1'b0, 8, 0, 1'b1}};
    tbl[10] = '{1, M_ZERO, '{1'b0, 1, 7, 1'b1}};

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      s = snap(d);
      check("reset A_OUT", s.a, 0);
      check("reset BUSY", s.busy, 0);
      check("reset DONE", s.done, 0);
      check("reset PASS", s.pass, 0);
      check("reset ERR_CNT", s.err, 0);
      check("reset FAIL_VEC", s.fvec, 0);
      check("reset FAIL_VALID", s.fvalid, 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run(tbl[i].dut, tbl[i].mode, tbl[i].exp);
    end

    // START held high: runs back to back, accepts at edges 0, 14, 28.
    r_and = '{1'b1, 0, 0, 1'b0};
    mode0 = M_AND;
    q0.push_back(r_and);
    q0.push_back(r_and);
    q0.push_back(r_and);
    ndone = 0; first = -1; second = -1;
    @(negedge clk);
    bus0.START = 1'b1;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      s = snap(0);
      if (s.done != 0) begin
        if (ndone == 0) first = k;
        else if (ndone == 1) second = k;
        ndone++;
      end
    end
    bus0.START = 1'b0;
    check("held START DONE count", ndone, 2);
    check("held START first DONE edge", first, 12);
    check("held START DONE spacing", second - first, 14);
    k = 0;
    s = snap(0);
    while (s.done == 0 && k < 30) begin
      @(negedge clk);
      k++;
      s = snap(0);
    end
    check("third run DONE edge", 29 + k, 40);
    repeat (2) @(negedge clk);

    // Asynchronous reset in DRIVE with A_OUT=2 during a failing run.
    mode0 = M_OR;
    @(negedge clk);
    bus0.START = 1'b1;
    @(negedge clk);
    bus0.START = 1'b0;
    k = 0;
    s = snap(0);
    while (s.a != 2 && k < 20) begin
      @(negedge clk);
      k++;
      s = snap(0);
    end
    check("reached A_OUT=2", s.a, 2);
    check("pre-reset ERR_CNT", s.err, 1);
    #1 rst_n = 1'b0;
    #1 s = snap(0);
    check("async rst A_OUT", s.a, 0);
    check("async rst BUSY", s.busy, 0);
    check("async rst DONE", s.done, 0);
    check("async rst PASS", s.pass, 0);
    check("async rst ERR_CNT", s.err, 0);
    check("async rst FAIL_VEC", s.fvec, 0);
    check("async rst FAIL_VALID", s.fvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      s = snap(0);
      if (s.done != 0 || s.busy != 0) ndone++;
    end
    check("no activity after reset", ndone, 0);
    run(0, M_AND, r_and);

    repeat (2) @(negedge clk);
    check("dut0 results outstanding", q0.size(), 0);
    check("dut1 results outstanding", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
